// File: rtl/pipelined_adder.sv
// Carry-segmented pipelined add/subtract; result on sum/out_valid STAGES+1 enabled edges after acceptance.
// No backpressure: ce=0 freezes every register, including out_valid, so consumers qualify out_valid with ce.
module pipelined_adder #(
  parameter int ADDER_WIDTH = 51,
  parameter int STAGES      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic                   in_valid,
  input  logic                   sub,
  input  logic [ADDER_WIDTH-1:0] a,
  input  logic [ADDER_WIDTH-1:0] b,
  output logic                   out_valid,
  output logic [ADDER_WIDTH:0]   sum
);

  localparam int W   = ADDER_WIDTH;
  localparam int S   = STAGES;
  localparam int SEG = (W + S - 1) / S;

  // Index k holds what stage k registered; stage 0 captures the operands.
  logic [W-1:0] a_q   [0:S-1];
  logic [W-1:0] b_q   [0:S-1];
  logic [W-1:0] s_q   [1:S];
  logic         c_q   [0:S];
  logic         v_q   [0:S];
  logic [W-1:0] s_nxt [1:S];
  logic         c_nxt [1:S];

  // Subtraction is a + ~b + 1, so the inversion and carry-in are folded in here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q[0] <= '0;
      b_q[0] <= '0;
      c_q[0] <= 1'b0;
      v_q[0] <= 1'b0;
    end else if (ce) begin
      a_q[0] <= a;
      b_q[0] <= sub ? ~b : b;
      c_q[0] <= sub;
      v_q[0] <= in_valid;
    end
  end

  for (genvar k = 1; k <= S; k++) begin : g_stage
    localparam int LO  = (k - 1) * SEG;
    localparam int HI  = (k * SEG < W) ? k * SEG : W;
    localparam int LEN = (HI > LO) ? HI - LO : 0;

    logic [W-1:0] prev;

    if (k == 1) begin : g_first
      assign prev = '0;
    end else begin : g_rest
      assign prev = s_q[k-1];
    end

    if (LEN > 0) begin : g_add
      logic [LEN:0] seg;
      logic [W-1:0] merged;

      assign seg = {1'b0, a_q[k-1][LO +: LEN]} + {1'b0, b_q[k-1][LO +: LEN]}
                   + (LEN + 1)'(c_q[k-1]);

      always_comb begin
        merged              = prev;
        merged[LO +: LEN]   = seg[LEN-1:0];
      end

      assign s_nxt[k] = merged;
      assign c_nxt[k] = seg[LEN];
    end else begin : g_empty
      // Segment beyond the top bit: the stage only adds delay.
      assign s_nxt[k] = prev;
      assign c_nxt[k] = c_q[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end else if (ce) begin
        s_q[k] <= s_nxt[k];
        c_q[k] <= c_nxt[k];
        v_q[k] <= v_q[k-1];
      end
    end

    if (k < S) begin : g_fwd
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end else if (ce) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
        end
      end
    end
  end

  // Bubble slots never load sum, so it always shows the last real result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
    end else if (ce) begin
      out_valid <= v_q[S];
      if (v_q[S]) begin
        sum <= {c_q[S], s_q[S]};
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed corner cases on the 51/3 instance plus a random sweep over several shapes.
module tb_pipelined_adder;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        ce       = 1'b0;
  logic        in_valid = 1'b0;
  logic        sub      = 1'b0;
  logic [63:0] a        = '0;
  logic [63:0] b        = '0;

  always #5 clk = ~clk;

  localparam logic [64:0] MAX51 = 65'h0_0007_FFFF_FFFF_FFFF;

  logic        ov0, ov1, ov2, ov3, ov4;
  logic [51:0] sum0;
  logic [1:0]  sum1;
  logic [8:0]  sum2;
  logic [51:0] sum3;
  logic [64:0] sum4;

  pipelined_adder #(.ADDER_WIDTH(51), .STAGES(3)) u_d0 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .sub(sub),
    .a(a[50:0]), .b(b[50:0]), .out_valid(ov0), .sum(sum0));
  pipelined_adder #(.ADDER_WIDTH(1), .STAGES(1)) u_d1 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .sub(sub),
    .a(a[0:0]), .b(b[0:0]), .out_valid(ov1), .sum(sum1));
  pipelined_adder #(.ADDER_WIDTH(8), .STAGES(3)) u_d2 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .sub(sub),
    .a(a[7:0]), .b(b[7:0]), .out_valid(ov2), .sum(sum2));
  pipelined_adder #(.ADDER_WIDTH(51), .STAGES(51)) u_d3 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .sub(sub),
    .a(a[50:0]), .b(b[50:0]), .out_valid(ov3), .sum(sum3));
  pipelined_adder #(.ADDER_WIDTH(64), .STAGES(4)) u_d4 (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .sub(sub),
    .a(a), .b(b), .out_valid(ov4), .sum(sum4));

  int w_tab [5] = '{51, 1, 8, 51, 64};
  int s_tab [5] = '{3, 1, 3, 51, 4};

  logic        ov [5];
  logic [64:0] sv [5];

  always_comb begin
    ov[0] = ov0; ov[1] = ov1; ov[2] = ov2; ov[3] = ov3; ov[4] = ov4;
    sv[0] = 65'(sum0); sv[1] = 65'(sum1); sv[2] = 65'(sum2);
    sv[3] = 65'(sum3); sv[4] = sum4;
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    int          edge_no;
  } acc_t;

  typedef struct {
    int          dut;
    logic [64:0] val;
    int          edge_no;
  } obs_t;

  acc_t acc_q [$];
  obs_t obs_q [$];
  int   en_edge     = 0;
  logic last_en     = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  // Accepted operations, stamped with the index of the enabled edge that took them.
  always @(posedge clk) begin
    last_en <= ce && !rst;
    if (ce && !rst) begin
      en_edge <= en_edge + 1;
      if (in_valid) acc_q.push_back('{a: a, b: b, sub: sub, edge_no: en_edge + 1});
    end
  end

  // A result counts once: out_valid seen after an enabled edge.
  always @(negedge clk) begin
    if (last_en) begin
      for (int d = 0; d < 5; d++) begin
        if (ov[d]) obs_q.push_back('{dut: d, val: sv[d], edge_no: en_edge});
      end
    end
  end

  function automatic logic [64:0] model(input int w, input logic [63:0] x, input logic [63:0] y,
                                        input logic s);
    logic [64:0] m, xx, yy, r;
    m  = (65'd1 << w) - 65'd1;
    xx = {1'b0, x} & m;
    yy = {1'b0, y} & m;
    if (!s) begin
      r = xx + yy;
    end else begin
      r = (xx - yy) & m;
      if (xx >= yy) r = r | (65'd1 << w);
    end
    return r;
  endfunction

  task automatic step(input logic v, input logic s, input logic [63:0] x, input logic [63:0] y,
                      input logic e);
    @(negedge clk);
    in_valid = v;
    sub      = s;
    a        = x;
    b        = y;
    ce       = e;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
  endtask

  task automatic clear_log;
    acc_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 5; d++) begin
      vectors++;
      if (ov[d] !== 1'b0 || sv[d] !== 65'd0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: out_valid=%b sum=%h, want 0 and 0", d, ov[d], sv[d]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_max_add;
    obs_t o [$];
    clear_log();
    step(1'b1, 1'b0, MAX51[63:0], MAX51[63:0], 1'b1);
    idle(60);
    foreach (obs_q[i]) if (obs_q[i].dut == 0) o.push_back(obs_q[i]);
    vectors++;
    if (o.size() !== 1) begin
      miscompares++;
      $display("FAIL max_add_count: got %0d results, want 1", o.size());
    end
    if (o.size() > 0 && acc_q.size() > 0) begin
      vectors++;
      if (o[0].val !== 65'h0_000F_FFFF_FFFF_FFFE) begin
        miscompares++;
        $display("FAIL max_add_value: got %h, want %h", o[0].val, 65'h0_000F_FFFF_FFFF_FFFE);
      end
      vectors++;
      if (o[0].edge_no !== acc_q[0].edge_no + 4) begin
        miscompares++;
        $display("FAIL max_add_latency: got edge %0d, want %0d", o[0].edge_no, acc_q[0].edge_no + 4);
      end
    end
  endtask

  task automatic test_sub;
    obs_t o [$];
    clear_log();
    step(1'b1, 1'b1, 64'd0, 64'd1, 1'b1);
    step(1'b1, 1'b1, 64'd5, 64'd5, 1'b1);
    idle(60);
    foreach (obs_q[i]) if (obs_q[i].dut == 0) o.push_back(obs_q[i]);
    vectors++;
    if (o.size() !== 2) begin
      miscompares++;
      $display("FAIL sub_count: got %0d results, want 2", o.size());
    end
    if (o.size() > 1) begin
      vectors++;
      if (o[0].val !== MAX51) begin
        miscompares++;
        $display("FAIL sub_borrow: got %h, want %h", o[0].val, MAX51);
      end
      vectors++;
      if (o[1].val !== 65'h0_0008_0000_0000_0000) begin
        miscompares++;
        $display("FAIL sub_equal: got %h, want %h", o[1].val, 65'h0_0008_0000_0000_0000);
      end
    end
  endtask

  task automatic test_back_to_back;
    obs_t o [$];
    clear_log();
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, MAX51[63:0], 64'(i), 1'b1);
    idle(60);
    foreach (obs_q[i]) if (obs_q[i].dut == 0) o.push_back(obs_q[i]);
    vectors++;
    if (o.size() !== 10) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results, want 10", o.size());
    end
    for (int i = 0; i < o.size() && i < 10 && i < acc_q.size(); i++) begin
      vectors++;
      if (o[i].val !== MAX51 + 65'(i + 1)) begin
        miscompares++;
        $display("FAIL b2b_value[%0d]: got %h, want %h", i, o[i].val, MAX51 + 65'(i + 1));
      end
      vectors++;
      if (o[i].edge_no !== acc_q[i].edge_no + 4 || o[i].edge_no !== o[0].edge_no + i) begin
        miscompares++;
        $display("FAIL b2b_timing[%0d]: got edge %0d, want %0d", i, o[i].edge_no, acc_q[i].edge_no + 4);
      end
    end
  endtask

  task automatic test_ce_stall;
    obs_t o [$];
    clear_log();
    step(1'b1, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    step(1'b1, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    repeat (3) step(1'b1, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'b0);
    idle(60);
    foreach (obs_q[i]) if (obs_q[i].dut == 0) o.push_back(obs_q[i]);
    vectors++;
    if (o.size() !== 2) begin
      miscompares++;
      $display("FAIL stall_count: got %0d results, want 2", o.size());
    end
    for (int i = 0; i < o.size() && i < 2 && i < acc_q.size(); i++) begin
      vectors++;
      if (o[i].val !== model(51, acc_q[i].a, acc_q[i].b, acc_q[i].sub)) begin
        miscompares++;
        $display("FAIL stall_value[%0d]: got %h, want %h", i, o[i].val,
                 model(51, acc_q[i].a, acc_q[i].b, acc_q[i].sub));
      end
      vectors++;
      if (o[i].edge_no !== acc_q[i].edge_no + 4) begin
        miscompares++;
        $display("FAIL stall_latency[%0d]: got edge %0d, want %0d", i, o[i].edge_no, acc_q[i].edge_no + 4);
      end
    end
  endtask

  task automatic test_reset_mid;
    int cnt [5];
    repeat (3) step(1'b1, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 5; d++) begin
      vectors++;
      if (ov[d] !== 1'b0 || sv[d] !== 65'd0) begin
        miscompares++;
        $display("FAIL midreset_clear dut%0d: out_valid=%b sum=%h, want 0 and 0", d, ov[d], sv[d]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    clear_log();
    rst      = 1'b0;
    in_valid = 1'b1;
    sub      = 1'($urandom);
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    ce       = 1'b1;
    idle(60);
    for (int d = 0; d < 5; d++) cnt[d] = 0;
    foreach (obs_q[i]) begin
      cnt[obs_q[i].dut]++;
      if (acc_q.size() > 0) begin
        vectors++;
        if (obs_q[i].val !== model(w_tab[obs_q[i].dut], acc_q[0].a, acc_q[0].b, acc_q[0].sub) ||
            obs_q[i].edge_no !== acc_q[0].edge_no + s_tab[obs_q[i].dut] + 1) begin
          miscompares++;
          $display("FAIL post_reset_op dut%0d: got %h at edge %0d, want %h at edge %0d",
                   obs_q[i].dut, obs_q[i].val, obs_q[i].edge_no,
                   model(w_tab[obs_q[i].dut], acc_q[0].a, acc_q[0].b, acc_q[0].sub),
                   acc_q[0].edge_no + s_tab[obs_q[i].dut] + 1);
        end
      end
    end
    for (int d = 0; d < 5; d++) begin
      vectors++;
      if (cnt[d] !== 1) begin
        miscompares++;
        $display("FAIL post_reset_count dut%0d: got %0d results, want 1", d, cnt[d]);
      end
    end
  endtask

  task automatic test_sweep;
    logic [63:0] x, y;
    clear_log();
    for (int n = 0; n < 400; n++) begin
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      if ($urandom_range(7) == 0) y = x;
      if ($urandom_range(7) == 0) x = '1;
      if ($urandom_range(7) == 0) y = '1;
      step($urandom_range(9) < 7, 1'($urandom), x, y, $urandom_range(4) != 0);
    end
    idle(70);
    for (int d = 0; d < 5; d++) begin
      obs_t o [$];
      foreach (obs_q[i]) if (obs_q[i].dut == d) o.push_back(obs_q[i]);
      vectors++;
      if (o.size() !== acc_q.size()) begin
        miscompares++;
        $display("FAIL sweep_count W=%0d S=%0d: got %0d results, want %0d",
                 w_tab[d], s_tab[d], o.size(), acc_q.size());
      end
      for (int i = 0; i < o.size() && i < acc_q.size(); i++) begin
        vectors++;
        if (o[i].val !== model(w_tab[d], acc_q[i].a, acc_q[i].b, acc_q[i].sub) ||
            o[i].edge_no !== acc_q[i].edge_no + s_tab[d] + 1) begin
          miscompares++;
          $display("FAIL sweep W=%0d S=%0d op%0d: got %h at edge %0d, want %h at edge %0d",
                   w_tab[d], s_tab[d], i, o[i].val, o[i].edge_no,
                   model(w_tab[d], acc_q[i].a, acc_q[i].b, acc_q[i].sub),
                   acc_q[i].edge_no + s_tab[d] + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_max_add();
    test_sub();
    test_back_to_back();
    test_ce_stall();
    test_reset_mid();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter ADDER_WIDTH, default 51: operand width in bits; legal range 1..256.
REQ-002 Parameter STAGES, default 3: number of carry-segment pipeline stages; legal range 1..ADDER_WIDTH.
REQ-003 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port ce, input, 1 bit: pipeline enable; 0 freezes every register in the block.
REQ-006 Port in_valid, input, 1 bit: a, b and sub carry a new operation this cycle.
REQ-007 Port sub, input, 1 bit: operation select; 0 means a+b, 1 means a-b.
REQ-008 Port a, input, ADDER_WIDTH bits: unsigned operand A.
REQ-009 Port b, input, ADDER_WIDTH bits: unsigned operand B.
REQ-010 Port out_valid, output, 1 bit: sum holds a newly completed result this cycle.
REQ-011 Port sum, output, ADDER_WIDTH+1 bits: registered result; bit ADDER_WIDTH is carry-out.

Function
REQ-012 SEG = ceil(ADDER_WIDTH/STAGES); segment k covers bits [k*SEG, min((k+1)*SEG, ADDER_WIDTH)-1].
REQ-013 Trailing segments with no bits are empty; they still occupy a pipeline stage and pass their carry through unchanged.
REQ-014 Stage 0: when ce=1, register a, b, sub and in_valid.
REQ-015 Stage 0: when sub=1, replace b with ~b and set the carry-in to 1; when sub=0, the carry-in is 0.
REQ-016 Stage k (k = 1..STAGES) adds segment k-1 of the operands plus the carry registered by stage k-1.
REQ-017 Stage k registers the partial sum bits of segment k-1 and the carry out of segment k-1.
REQ-018 Operand bits not yet consumed shall be delayed alongside each stage; completed sum bits shall be delayed until the final stage, so results leave aligned.
REQ-019 sum register: on the cycle the final stage's valid is 1 and ce=1, load the concatenation {final carry, all segment sums}.
REQ-020 sum register: otherwise, hold its previous value.
REQ-021 out_valid shall equal the final-stage valid registered under ce; it is high for exactly one enabled cycle per accepted operation.
REQ-022 Latency: an operation accepted at enabled edge N appears on sum/out_valid after enabled edge N+STAGES+1; it is visible in the following cycle.
REQ-023 Throughput: one operation per enabled cycle, with no bubbles inserted.
REQ-024 Add result: sum = a + b, exact (ADDER_WIDTH+1)-bit value.
REQ-025 Sub result: sum[ADDER_WIDTH-1:0] = (a - b) mod 2^ADDER_WIDTH.
REQ-026 Sub result: sum[ADDER_WIDTH] = 1 when a >= b (no borrow) and 0 otherwise.
REQ-027 in_valid=0 slots shall propagate as bubbles; data in bubble slots is don't-care and never reaches sum.
REQ-028 ce=0: all data, carry and valid registers hold their values.
REQ-029 ce=0: in_valid, a, b and sub are ignored that cycle.
REQ-030 ce=0: out_valid holds its current value; a downstream consumer shall qualify out_valid with ce.
REQ-031 ce toggling shall not drop, duplicate or reorder operations.
REQ-032 STAGES=1 degenerates to a registered adder with latency 2, matching REQ-022.

Reset
REQ-033 rst=1 asynchronously clears every valid bit, carry register, operand register and sum register, and sets out_valid to 0, regardless of ce.
REQ-034 Operations in flight at reset are discarded, with no partial result emitted.
REQ-035 The first enabled edge after rst falls shall accept a new operation normally.

Verification
REQ-036 W=51, S=3, add a=b=2^51-1 with ce=1: out_valid pulses one cycle after the 4th edge; sum=2^52-2.
REQ-037 Sub a=0, b=1: sum[50:0]=2^51-1, sum[51]=0. Sub a=5, b=5: sum=2^51 (carry 1, low bits 0).
REQ-038 Back-to-back carry chain: 10 consecutive valid adds with a=2^51-1 and b=i (i=1..10): 10 consecutive out_valid cycles; sum=2^51-1+i, in order.
REQ-039 ce stall: ce held 0 for 3 cycles with 2 ops in flight: outputs stall; both results emerge in order with correct values; no duplicate out_valid.
REQ-040 Reset mid-operation: assert rst asynchronously with 3 ops in flight: out_valid=0 and sum=0 immediately, and no stale result appears afterwards.
REQ-041 Parameter sweep (W,S) in {(1,1), (8,3), (51,51), (64,4)}: random a, b, sub compared against the reference model; latency S+1 holds for each.
